traffic_scheduler: RTL and testbench
====================================

TRAFFIC_SCHEDULER -- requirements
Module: traffic_scheduler

Interface
REQ-001 The block SHALL have parameter BASE_TICKS, default 12500000, meaning i_Clk cycles per base tick (0.5 s at 25 MHz).
REQ-002 The block SHALL have parameter MAX_X, default 20, meaning the highest car column; the lane spans 0..MAX_X.
REQ-003 The block SHALL have parameter NUM_LANES, default 4, meaning the number of car lanes scheduled; only 4 is supported.
REQ-004 The block SHALL have port i_Clk, input, 1 bit: the single 25 MHz clock.
REQ-005 The block SHALL have port i_Rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port i_Start, input, 1 bit: one-cycle pulse that starts or restarts traffic.
REQ-007 The block SHALL have port i_Pause, input, 1 bit: level; while high, traffic is frozen.
REQ-008 The block SHALL have port i_Collision, input, 1 bit: one-cycle pulse from frog/car hit detection.
REQ-009 The block SHALL have port i_Level, input, 2 bits: game level 0..3; a higher level gives faster cars.
REQ-010 The block SHALL have port o_Car_X, output, 20 bits: packed car columns; lane n is at [5n+4:5n].
REQ-011 The block SHALL have port o_Lane_Step, output, 4 bits: bit n pulses for one cycle when lane n moves.
REQ-012 The block SHALL have port o_State, output, 2 bits, encoded IDLE=0, RUN=1, PAUSED=2, CRASHED=3.

Function
REQ-013 The base counter SHALL count 0..BASE_TICKS-1 only in RUN, and SHALL emit an internal one-cycle tick when it wraps from BASE_TICKS-1 to 0.
REQ-014 Each lane n SHALL have a tick counter and a period P(n) = max(1, D(n) - i_Level), where D = {4, 3, 2, 2} for lanes 0..3.
REQ-015 On a tick, a lane whose counter is >= P(n)-1 SHALL step and clear its counter; otherwise its counter SHALL increment.
REQ-016 i_Level SHALL be sampled combinationally at each tick; lowering P(n) below the current count causes a step on the next tick, with no skipped or double steps.
REQ-017 A step SHALL move even lanes +1, wrapping MAX_X->0, and odd lanes -1, wrapping 0->MAX_X; no value > MAX_X SHALL ever appear.
REQ-018 The new o_Car_X value and its o_Lane_Step bit SHALL appear on the same edge: the edge after the base counter holds BASE_TICKS-1.
REQ-019 The start columns SHALL be lane0=0, lane1=5, lane2=10, lane3=15.
REQ-020 In IDLE, o_Car_X SHALL hold the start columns and all counters SHALL be 0.
REQ-021 IDLE SHALL go to RUN on i_Start.
REQ-022 RUN SHALL go to CRASHED on i_Collision; else restart on i_Start (reload start columns, clear counters, stay in RUN); else go to PAUSED if i_Pause=1.
REQ-023 PAUSED SHALL go to CRASHED on i_Collision; else to RUN on i_Start (with reload); else to RUN when i_Pause=0, resuming all counters unchanged.
REQ-024 CRASHED SHALL freeze positions and counters, ignore i_Pause and i_Collision, and go to RUN with reload on i_Start.
REQ-025 Same-cycle priority SHALL be Collision > Start > Pause.
REQ-026 A step due on the same cycle as an entry to PAUSED or CRASHED SHALL be suppressed, with positions left unchanged.
REQ-027 o_Lane_Step SHALL be 0 in every state except on RUN step cycles.

Reset
REQ-028 While i_Rst=1, the block SHALL asynchronously force IDLE, o_Car_X to the start columns, o_Lane_Step=0, o_State=0, and all counters to 0, regardless of i_Clk.
REQ-029 After i_Rst deasserts, the block SHALL remain in IDLE until i_Start; reset in mid-RUN discards all progress.

Verification (BASE_TICKS=4 for simulation)
REQ-030 The bench SHALL check: reset, then i_Start, i_Level=0 -> lane3 steps 15->14 after 8 cycles and lane0 steps 0->1 after 16 cycles, each with a one-cycle o_Lane_Step.
REQ-031 The bench SHALL check: i_Level=3, run 21 ticks -> lane0 returns to 0 (wrap 20->0) and lane1 returns to 5 (wrap 0->20).
REQ-032 The bench SHALL check: i_Pause high for 50 cycles mid-run -> o_Car_X and o_Lane_Step are constant, o_State=2, and the next step lands exactly 50 cycles later than without the pause.
REQ-033 The bench SHALL check: i_Collision and i_Start in the same RUN cycle -> o_State=3 and positions frozen; a later i_Start -> o_State=1 and o_Car_X=start columns.
REQ-034 The bench SHALL check: i_Rst asserted between clock edges mid-run -> outputs reach reset values before the next i_Clk edge.
REQ-035 The bench SHALL check: i_Level changed 0->3 when lane0 counter=2 -> lane0 steps on the next tick.

Source files
------------

// File: rtl/traffic_scheduler.sv
// Frogger traffic scheduler: advances four car lanes at level-dependent rates
// and runs the IDLE/RUN/PAUSED/CRASHED game-flow state machine.
module traffic_scheduler #(
    parameter int BASE_TICKS = 12500000,
    parameter int MAX_X      = 20,
    parameter int NUM_LANES  = 4
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Start,
    input  logic        i_Pause,
    input  logic        i_Collision,
    input  logic [1:0]  i_Level,
    output logic [19:0] o_Car_X,
    output logic [3:0]  o_Lane_Step,
    output logic [1:0]  o_State
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_CRASHED = 2'd3;

    localparam int                BASE_W    = (BASE_TICKS > 1) ? $clog2(BASE_TICKS) : 1;
    localparam logic [BASE_W-1:0] BASE_LAST = BASE_W'(BASE_TICKS - 1);
    localparam logic [4:0]        X_LAST    = 5'(MAX_X);

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic [BASE_W-1:0] base_reg;
    logic              reload;
    logic              advance;
    logic              tick;
    logic [19:0]       car_x_w;
    logic [3:0]        step_w;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_Start) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (i_Collision)  state_next = ST_CRASHED;
                else if (i_Start) state_next = ST_RUN;
                else if (i_Pause) state_next = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (i_Collision)              state_next = ST_CRASHED;
                else if (i_Start || !i_Pause) state_next = ST_RUN;
            end
            default: begin
                if (i_Start) state_next = ST_RUN;
            end
        endcase
    end

    // Time only accrues on cycles that end in RUN without a (re)start, so a
    // tick due on pause entry is held and fires on the resume edge instead.
    assign reload  = i_Start && (state_next == ST_RUN);
    assign advance = !i_Start && (state_next == ST_RUN);
    assign tick    = advance && (base_reg == BASE_LAST);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            base_reg <= '0;
        end else if (reload) begin
            base_reg <= '0;
        end else if (advance) begin
            base_reg <= tick ? '0 : base_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            localparam int         DELAY   = (gi == 0) ? 4 : (gi == 1) ? 3 : 2;
            localparam logic [4:0] X_START = 5'(5 * gi);

            logic [2:0] cnt_reg;
            logic [4:0] x_reg;
            logic       step_reg;
            logic [2:0] period;
            logic       due;
            logic [4:0] x_next;

            assign period = (DELAY > int'(i_Level)) ? 3'(DELAY - int'(i_Level)) : 3'd1;
            // ">=" lets a lowered period take effect on the very next tick
            assign due    = (cnt_reg >= period - 3'd1);

            if (gi % 2 == 0) begin : g_fwd
                assign x_next = (x_reg >= X_LAST) ? 5'd0 : x_reg + 5'd1;
            end else begin : g_rev
                assign x_next = (x_reg == 5'd0) ? X_LAST : x_reg - 5'd1;
            end

            always_ff @(posedge i_Clk or posedge i_Rst) begin
                if (i_Rst) begin
                    cnt_reg  <= '0;
                    x_reg    <= X_START;
                    step_reg <= 1'b0;
                end else begin
                    step_reg <= 1'b0;
                    if (reload) begin
                        cnt_reg <= '0;
                        x_reg   <= X_START;
                    end else if (tick) begin
                        if (due) begin
                            cnt_reg  <= '0;
                            x_reg    <= x_next;
                            step_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 3'd1;
                        end
                    end
                end
            end

            assign car_x_w[5*gi +: 5] = x_reg;
            assign step_w[gi]         = step_reg;
        end
    endgenerate

    always_comb begin
        o_State     = state_reg;
        o_Car_X     = car_x_w;
        o_Lane_Step = step_w;
    end

endmodule

// File: tb/tb_traffic_scheduler.sv
// Randomized scoreboard bench for traffic_scheduler with directed scenarios
// for start timing, wrap, pause, crash, async reset and level change.
module tb_traffic_scheduler;

    localparam int BT   = 4;
    localparam int MAXX = 20;
    localparam logic [19:0] START = {5'd15, 5'd10, 5'd5, 5'd0};

    logic        i_Clk = 1'b0;
    logic        i_Rst = 1'b1;
    logic        i_Start = 1'b0;
    logic        i_Pause = 1'b0;
    logic        i_Collision = 1'b0;
    logic [1:0]  i_Level = 2'd0;
    logic [19:0] o_Car_X;
    logic [3:0]  o_Lane_Step;
    logic [1:0]  o_State;

    traffic_scheduler #(.BASE_TICKS(BT), .MAX_X(MAXX), .NUM_LANES(4)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Pause(i_Pause),
        .i_Collision(i_Collision), .i_Level(i_Level),
        .o_Car_X(o_Car_X), .o_Lane_Step(o_Lane_Step), .o_State(o_State)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
        logic [19:0] car;
    } step_t;

    step_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model: game state, run-time cycles since (re)start, lane counters and columns
    int lane_d[4]    = '{4, 3, 2, 2};
    int start_col[4] = '{0, 5, 10, 15};
    int m_state;
    int m_run;
    int m_cnt[4];
    int m_x[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [19:0] model_car();
        logic [19:0] r;
        r = '0;
        for (int l = 0; l < 4; l++) r[5*l +: 5] = 5'(m_x[l]);
        return r;
    endfunction

    task automatic model_restart();
        m_state = 1;
        m_run   = 0;
        for (int l = 0; l < 4; l++) begin
            m_cnt[l] = 0;
            m_x[l]   = start_col[l];
        end
    endtask

    task automatic model_reset();
        model_restart();
        m_state = 0;
        exp_q.delete();
    endtask

    task automatic model_tick();
        step_t e;
        int p;
        e.mask = '0;
        for (int l = 0; l < 4; l++) begin
            p = lane_d[l] - int'(i_Level);
            if (p < 1) p = 1;
            if (m_cnt[l] >= p - 1) begin
                m_cnt[l] = 0;
                m_x[l] = (l % 2 == 0) ? (m_x[l] + 1) % (MAXX + 1) : (m_x[l] + MAXX) % (MAXX + 1);
                e.mask[l] = 1'b1;
            end else begin
                m_cnt[l]++;
            end
        end
        if (e.mask != 0) begin
            e.cyc = cyc;
            e.car = model_car();
            exp_q.push_back(e);
        end
    endtask

    task automatic model_edge();
        bit run;
        cyc++;
        run = 0;
        if (i_Rst) begin
            model_reset();
            return;
        end
        case (m_state)
            0: if (i_Start) model_restart();
            1: begin
                if (i_Collision)  m_state = 3;
                else if (i_Start) model_restart();
                else if (i_Pause) m_state = 2;
                else              run = 1;
            end
            2: begin
                if (i_Collision)   m_state = 3;
                else if (i_Start)  model_restart();
                else if (!i_Pause) begin m_state = 1; run = 1; end
            end
            default: if (i_Start) model_restart();
        endcase
        if (run) begin
            m_run++;
            if (m_run % BT == 0) model_tick();
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge i_Clk);
            model_edge();
        end
    end

    task automatic monitor_cycle();
        step_t e;
        check("state", 32'(o_State), 32'(m_state));
        check("car_x", 32'(o_Car_X), 32'(model_car()));
        if (o_Lane_Step != 0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_step", 32'(o_Lane_Step), 0);
            end else begin
                e = exp_q.pop_front();
                check("step_cycle", cyc, e.cyc);
                check("step_mask", 32'(o_Lane_Step), 32'(e.mask));
                check("step_car", 32'(o_Car_X), 32'(e.car));
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check("missed_step", 32'(o_Lane_Step), 32'(e.mask));
        end
    endtask

    initial begin
        forever begin
            @(negedge i_Clk);
            monitor_cycle();
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int e0;

    task automatic pulse_start();
        i_Start = 1'b1;
        @(posedge i_Clk);
        #1;
        e0 = cyc;
        i_Start = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        do @(negedge i_Clk); while (cyc < target);
    endtask

    task automatic wait_lane(input int lane, input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget && at < 0; k++) begin
            @(negedge i_Clk);
            if (o_Lane_Step[lane]) at = cyc;
        end
    endtask

    initial begin
        int at;
        logic [19:0] snap;
        bit hold_ok;

        // Reset state and IDLE hold after release
        repeat (3) @(posedge i_Clk);
        @(negedge i_Clk);
        check("reset_state", 32'(o_State), 0);
        check("reset_car", 32'(o_Car_X), 32'(START));
        @(posedge i_Clk); #1 i_Rst = 1'b0;
        repeat (5) @(negedge i_Clk);
        check("idle_after_reset", 32'(o_State), 0);

        // First steps at level 0
        pulse_start();
        wait_lane(3, 20, at);
        check("lane3_first_step_delay", at - e0, 8);
        check("lane3_col", 32'(o_Car_X[19:15]), 14);
        @(negedge i_Clk);
        check("lane3_pulse_width", 32'(o_Lane_Step[3]), 0);
        wait_lane(0, 20, at);
        check("lane0_first_step_delay", at - e0, 16);
        check("lane0_col", 32'(o_Car_X[4:0]), 1);

        // Level raised while lane0 count is 2
        pulse_start();
        wait_cyc(e0 + 8);
        i_Level = 2'd3;
        wait_lane(0, 20, at);
        check("level_change_step_delay", at - e0, 12);

        // 21 ticks at level 3 wrap every lane back to its start column
        pulse_start();
        wait_cyc(e0 + 80);
        check("lane0_before_wrap", 32'(o_Car_X[4:0]), 20);
        wait_cyc(e0 + 84);
        check("wrap_car", 32'(o_Car_X), 32'(START));
        check("wrap_step_mask", 32'(o_Lane_Step), 32'hF);

        // 50-cycle pause delays lane3's second tick by exactly 50 cycles
        i_Level = 2'd0;
        pulse_start();
        @(posedge i_Clk);
        @(posedge i_Clk);
        #1 i_Pause = 1'b1;
        hold_ok = 1;
        snap = '0;
        for (int c = e0 + 3; c <= e0 + 52; c++) begin
            wait_cyc(c);
            if (c == e0 + 3) snap = o_Car_X;
            if (o_Car_X != snap || o_Lane_Step != 0 || o_State != 2'd2) hold_ok = 0;
        end
        check("pause_state", 32'(o_State), 2);
        check("pause_hold", 32'(hold_ok), 1);
        i_Pause = 1'b0;
        wait_lane(3, 100, at);
        check("pause_step_delay", at - e0, 58);

        // Collision and start together: collision wins
        snap = o_Car_X;
        i_Collision = 1'b1;
        i_Start = 1'b1;
        @(posedge i_Clk); #1;
        i_Collision = 1'b0;
        i_Start = 1'b0;
        @(negedge i_Clk);
        check("crash_state", 32'(o_State), 3);
        check("crash_freeze", 32'(o_Car_X), 32'(snap));
        i_Pause = 1'b1;
        @(posedge i_Clk); #1 i_Collision = 1'b1;
        @(posedge i_Clk); #1 i_Collision = 1'b0;
        repeat (10) @(posedge i_Clk);
        #1 i_Pause = 1'b0;
        @(negedge i_Clk);
        check("crash_ignores_inputs", 32'(o_State), 3);
        check("crash_still_frozen", 32'(o_Car_X), 32'(snap));
        pulse_start();
        @(negedge i_Clk);
        check("restart_state", 32'(o_State), 1);
        check("restart_car", 32'(o_Car_X), 32'(START));

        // Async reset between edges mid-run
        repeat (20) @(negedge i_Clk);
        #2 i_Rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_state", 32'(o_State), 0);
        check("async_rst_car", 32'(o_Car_X), 32'(START));
        check("async_rst_step", 32'(o_Lane_Step), 0);
        @(posedge i_Clk); #1 i_Rst = 1'b0;
        repeat (10) @(negedge i_Clk);
        check("idle_after_async_rst", 32'(o_State), 0);

        // Randomized traffic against the reference model
        @(posedge i_Clk); #1;
        pulse_start();
        for (int i = 0; i < 3000; i++) begin
            @(posedge i_Clk);
            #1;
            if (i_Rst) i_Rst = 1'b0;
            i_Start     = ($urandom_range(99) == 0);
            i_Collision = ($urandom_range(149) == 0);
            if ($urandom_range(39) == 0) i_Pause = ~i_Pause;
            if ($urandom_range(49) == 0) i_Level = 2'($urandom_range(3));
            if ($urandom_range(999) == 0) begin
                i_Rst = 1'b1;
                model_reset();
            end
        end
        i_Rst = 1'b0;
        i_Start = 1'b0;
        i_Collision = 1'b0;
        repeat (4) @(negedge i_Clk);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
